// File: rtl/pc_sequencer.sv
// pc_sequencer: next-PC generator and fetch/decode/execute sequencing FSM.
// The next PC is computed and registered in DECODE (sequential, conditional
// relative branch, jump, call, return). It is then handed to the PC register
// with a one-cycle pcEn pulse at the end of EXECUTE. Calls and returns go
// through a small return-address stack.
//
// Handshake: op_valid is a qualifier only, with no ready back to the decoder.
// The op fields are consumed on the rising edge that ends a DECODE cycle in
// which op_valid=1. The PC register loads next_pc on the rising edge that ends
// the cycle with pcEn=1.
module pc_sequencer #(
  parameter int PC_W      = 10,
  parameter int RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            run,
  input  logic [PC_W-1:0] pc,
  input  logic            op_valid,
  input  logic [2:0]      op_kind,
  input  logic            cond,
  input  logic [7:0]      disp,
  input  logic [PC_W-1:0] target,
  input  logic            mem_wait,
  output logic            fetch_req,
  output logic [PC_W-1:0] next_pc,
  output logic            pcEn,
  output logic            halted,
  output logic            ras_err,
  output logic [2:0]      dbg_state
);

  localparam int AW = $clog2(RAS_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_DECODE  = 3'd2,
    S_EXECUTE = 3'd3,
    S_HALT    = 3'd4
  } state_t;

  state_t state, state_nx;

  logic [PC_W-1:0] ras_mem [RAS_DEPTH];
  logic [CW-1:0]   ras_cnt;

  logic            capture;
  logic            ras_full, ras_empty;
  logic [AW-1:0]   top_idx;
  logic [PC_W-1:0] pc_inc, pc_rel, npc_d;
  logic            do_push, do_pop, err_d;

  // State register; reset returns the FSM to IDLE without a clock edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Next-state logic; run is only sampled in IDLE and at the end of EXECUTE.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:    if (run) state_nx = S_FETCH;
      S_FETCH:   state_nx = S_DECODE;
      S_DECODE:  if (op_valid) state_nx = (op_kind == 3'b101) ? S_HALT : S_EXECUTE;
      S_EXECUTE: if (!mem_wait) state_nx = run ? S_FETCH : S_IDLE;
      S_HALT:    state_nx = S_HALT;
      default:   state_nx = S_IDLE;
    endcase
  end

  // Outputs decoded straight from state so async reset clears them at once.
  always_comb begin
    fetch_req = (state == S_FETCH);
    pcEn      = (state == S_EXECUTE) && !mem_wait;
    halted    = (state == S_HALT);
    dbg_state = state;
  end

  // Next-PC candidate and stack action for the op currently at decode.
  always_comb begin
    capture   = (state == S_DECODE) && op_valid;
    ras_full  = (ras_cnt == CW'(RAS_DEPTH));
    ras_empty = (ras_cnt == '0);
    top_idx   = ras_cnt[AW-1:0] - AW'(1);
    pc_inc    = pc + PC_W'(1);
    pc_rel    = pc + {{(PC_W-8){disp[7]}}, disp};
    npc_d     = pc_inc;
    do_push   = 1'b0;
    do_pop    = 1'b0;
    err_d     = 1'b0;
    case (op_kind)
      3'b001: npc_d = cond ? pc_rel : pc_inc;
      3'b010: npc_d = target;
      3'b011: begin
        // A call on a full stack still jumps; only the return address is lost.
        npc_d = target;
        if (ras_full) err_d   = 1'b1;
        else          do_push = 1'b1;
      end
      3'b100: begin
        if (ras_empty) begin
          err_d = 1'b1;
          npc_d = pc_inc;
        end else begin
          npc_d  = ras_mem[top_idx];
          do_pop = 1'b1;
        end
      end
      3'b101:  npc_d = next_pc;
      default: npc_d = pc_inc;
    endcase
  end

  // Datapath registers; all commit only on the decode capture edge, so
  // mem_wait stretching can never repeat a push or pop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      next_pc <= '0;
      ras_cnt <= '0;
      ras_err <= 1'b0;
      for (int i = 0; i < RAS_DEPTH; i++) ras_mem[i] <= '0;
    end else if (capture) begin
      next_pc <= npc_d;
      if (err_d) ras_err <= 1'b1;
      if (do_push) begin
        ras_mem[ras_cnt[AW-1:0]] <= pc_inc;
        ras_cnt <= ras_cnt + CW'(1);
      end else if (do_pop) begin
        ras_cnt <= ras_cnt - CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed and random instructions, a queue-based
// reference model of next-PC and return stack, and a monitor that checks
// every pcEn pulse against the expected queue.
module tb_pc_sequencer;

  localparam int PC_W = 10;
  localparam int RAS_DEPTH = 4;
  localparam int EW = PC_W + 9;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            run = 1'b0;
  logic [PC_W-1:0] pc = '0;
  logic            op_valid = 1'b0;
  logic [2:0]      op_kind = '0;
  logic            cond = 1'b0;
  logic [7:0]      disp = '0;
  logic [PC_W-1:0] target = '0;
  logic            mem_wait = 1'b0;
  logic            fetch_req;
  logic [PC_W-1:0] next_pc;
  logic            pcEn;
  logic            halted;
  logic            ras_err;
  logic [2:0]      dbg_state;

  pc_sequencer #(.PC_W(PC_W), .RAS_DEPTH(RAS_DEPTH)) dut (
    .clk(clk), .reset(reset), .run(run), .pc(pc), .op_valid(op_valid),
    .op_kind(op_kind), .cond(cond), .disp(disp), .target(target),
    .mem_wait(mem_wait), .fetch_req(fetch_req), .next_pc(next_pc),
    .pcEn(pcEn), .halted(halted), .ras_err(ras_err), .dbg_state(dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // scoreboard state: entry = {latency[7:0], ras_err, next_pc}
  logic [EW-1:0]   exp_q[$];
  logic [PC_W-1:0] m_ras[$];
  logic [PC_W-1:0] m_npc;
  logic            m_err;
  int              n_cmp = 0;
  int              n_bad = 0;
  int              cyc = 0;
  int              fetch_cyc = 0;
  bit              exec_wait = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // behavioural reference: next PC and stack from the instruction rules
  task automatic model_step(input logic [2:0] k, input logic c, input logic [7:0] ds,
                            input logic [PC_W-1:0] tg, input logic [PC_W-1:0] pv);
    int sd;
    sd = (ds > 8'd127) ? int'(ds) - 256 : int'(ds);
    case (k)
      3'd1: m_npc = c ? PC_W'(int'(pv) + sd) : PC_W'(int'(pv) + 1);
      3'd2: m_npc = tg;
      3'd3: begin
        m_npc = tg;
        if (m_ras.size() >= RAS_DEPTH) m_err = 1'b1;
        else m_ras.push_back(PC_W'(int'(pv) + 1));
      end
      3'd4: begin
        if (m_ras.size() == 0) begin
          m_err = 1'b1;
          m_npc = PC_W'(int'(pv) + 1);
        end else m_npc = m_ras.pop_back();
      end
      3'd5: m_npc = m_npc;
      default: m_npc = PC_W'(int'(pv) + 1);
    endcase
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    chk("rst_pcen", pcEn, 0);
    chk("rst_next_pc", next_pc, 0);
    chk("rst_fetch_req", fetch_req, 0);
    chk("rst_halted", halted, 0);
    chk("rst_ras_err", ras_err, 0);
    exp_q.delete();
    m_ras.delete();
    m_npc = '0;
    m_err = 1'b0;
    exec_wait = 0;
    op_valid = 1'b0;
    mem_wait = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic wait_fetch();
    int n = 0;
    while (!fetch_req && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!fetch_req) chk("fetch_timeout", 0, 1);
  endtask

  // driver: one instruction with d decode stalls and w execute waits
  task automatic do_instr(input logic [2:0] k, input logic c, input logic [7:0] ds,
                          input logic [PC_W-1:0] tg, input logic [PC_W-1:0] pv,
                          input int d, input int w, input bit abort);
    wait_fetch();
    model_step(k, c, ds, tg, pv);
    if (k != 3'd5 && !abort) exp_q.push_back({8'(d + w + 2), m_err, m_npc});
    pc = pv; op_kind = k; cond = c; disp = ds; target = tg; op_valid = 1'b0;
    @(posedge clk); #1;
    repeat (d) begin @(posedge clk); #1; end
    op_valid = 1'b1;
    mem_wait = (w > 0);
    @(posedge clk); #1;
    op_valid = 1'b0;
    if (w > 0) exec_wait = 1;
    repeat (w) begin @(posedge clk); #1; end
    exec_wait = 0;
    mem_wait = 1'b0;
    if (abort) begin
      #1 chk("pcen_pre_abort", pcEn, 1);
      do_reset();
    end else begin
      @(posedge clk); #1;
    end
  endtask

  // monitor: compares every pcEn pulse against the head of the queue
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (reset) begin
      cyc++;
      if (fetch_req) fetch_cyc = cyc;
      if (exec_wait) begin
        chk("pcen_in_wait", pcEn, 0);
        if (exp_q.size() > 0) chk("npc_stable", next_pc, exp_q[0][PC_W-1:0]);
      end
      if (pcEn) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL spurious_pcen: got pcEn=1 expected 0 at %0t", $time);
        end else begin
          e = exp_q.pop_front();
          chk("next_pc", next_pc, e[PC_W-1:0]);
          chk("ras_err", ras_err, e[PC_W]);
          chk("latency", cyc - fetch_cyc, e[EW-1:PC_W+1]);
        end
      end
    end
  end

  initial begin
    logic [2:0] k;
    do_reset();
    run = 1'b1;
    // back-to-back sequential ops
    for (int i = 0; i < 3; i++) do_instr(3'd0, 0, 8'h00, '0, 10'h000, 0, 0, 0);
    // branches and wrap-around
    do_instr(3'd1, 1, 8'hFD, '0, 10'h005, 0, 0, 0);
    do_instr(3'd1, 0, 8'hFD, '0, 10'h005, 1, 0, 0);
    do_instr(3'd0, 0, 8'h00, '0, 10'h3FF, 0, 0, 0);
    do_instr(3'd1, 1, 8'hFE, '0, 10'h001, 0, 1, 0);
    do_instr(3'd2, 0, 8'h00, 10'h2A5, 10'h010, 0, 0, 0);
    // call / return pair
    do_instr(3'd3, 0, 8'h00, 10'h100, 10'h010, 0, 0, 0);
    do_instr(3'd4, 0, 8'h00, '0, 10'h120, 0, 0, 0);
    // randomized instruction mix
    for (int i = 0; i < 40; i++) begin
      k = 3'($urandom_range(0, 7));
      if (k == 3'd5) k = 3'd7;
      do_instr(k, 1'($urandom_range(0, 1)), 8'($urandom), PC_W'($urandom), PC_W'($urandom),
               $urandom_range(0, 2), $urandom_range(0, 2), 0);
    end
    do_reset();
    // stack overflow, LIFO returns, underflow
    for (int i = 0; i < 5; i++) do_instr(3'd3, 0, 8'h00, PC_W'(10'h030 + i), PC_W'(10'h020 + i), 0, 0, 0);
    for (int i = 0; i < 4; i++) do_instr(3'd4, 0, 8'h00, '0, PC_W'(10'h200 + i), 0, 0, 0);
    do_instr(3'd4, 0, 8'h00, '0, 10'h050, 0, 0, 0);
    // mem_wait stretch
    do_instr(3'd0, 0, 8'h00, '0, 10'h0AB, 0, 4, 0);
    // reset while pcEn is high
    do_instr(3'd2, 0, 8'h00, 10'h155, 10'h001, 0, 0, 1);
    run = 1'b1;
    do_instr(3'd0, 0, 8'h00, '0, 10'h07F, 0, 0, 0);
    // halt: sticky, no pcEn, next_pc unchanged
    do_instr(3'd5, 0, 8'h00, '0, 10'h300, 0, 0, 0);
    chk("halted_set", halted, 1);
    chk("halt_next_pc", next_pc, m_npc);
    repeat (20) @(posedge clk);
    #1 chk("halted_hold", halted, 1);
    chk("queue_drained", exp_q.size(), 0);
    do_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
